vram_board_painter: RTL and testbench

Sequencer that renders the chessboard background into the VRAM back buffer through the VRAM write port, then swaps the displayed frame. It sits beside the VGA text/palette interface and owns VRAM port B for writes. It replaces the per-pixel combinational board draw with one full-frame fill per command, with the frame swap aligned to vertical sync. Each VRAM byte is an 8-bit palette index covering a 2×2 pixel cell; each word covers 8×2 pixels; there are 80 words per row and 240 rows.

---
 rtl/vram_board_painter_if.sv | 37 +++
 rtl/vram_board_painter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_vram_board_painter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_board_painter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_board_painter_if
//  Description : VRAM port B write bus. The painter drives the request side
//                (master); the VRAM port grants each word with WR_READY
//                (slave).
//  Signals     : WR_EN      - write request
//                WR_ADDR    - 15-bit word address
//                WR_DATA    - 32-bit word, byte n = palette index of pair n
//                WR_BYTE_EN - byte enables (all ones while WR_EN=1)
//                WR_READY   - port accepts the write this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface vram_board_painter_if;
    logic        WR_EN;
    logic [14:0] WR_ADDR;
    logic [31:0] WR_DATA;
    logic [3:0]  WR_BYTE_EN;
    logic        WR_READY;

    modport master (
        output WR_EN,
        output WR_ADDR,
        output WR_DATA,
        output WR_BYTE_EN,
        input  WR_READY
    );

    modport slave (
        input  WR_EN,
        input  WR_ADDR,
        input  WR_DATA,
        input  WR_BYTE_EN,
        output WR_READY
    );
endinterface
`default_nettype wire

// File: rtl/vram_board_painter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_board_painter
//  Description : Renders the chessboard background into the VRAM back buffer
//                (one full-frame fill per START), then swaps the displayed
//                frame. Each word covers 8x2 pixels (4 pixel pairs, one byte
//                each); 80 words per row, 240 rows.
//  Ports       : CLK, RESET      - clock, synchronous active-high reset
//                START           - fill request, accepted only when idle
//                BKG/WHT/BLK_IDX - palette indices, latched on accepted START
//                VS              - active-low vsync (swap alignment)
//                wr              - VRAM write bus (master modport)
//                FRAME           - buffer currently displayed
//                BUSY            - sequencer not idle
//                DONE            - one-cycle pulse when FRAME toggles
//  Options     : PAINTER_VSYNC_SWAP_EN - when defined, the swap waits for a
//                falling edge of VS after the fill; when undefined the swap
//                follows the final write immediately and VS is unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_board_painter #(
    parameter int WORDS_PER_ROW = 80,
    parameter int ROWS          = 240
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic [7:0]                  BKG_IDX,
    input  logic [7:0]                  WHT_IDX,
    input  logic [7:0]                  BLK_IDX,
    input  logic                        VS,
    vram_board_painter_if.master        wr,
    output logic                        FRAME,
    output logic                        BUSY,
    output logic                        DONE
);

    localparam logic [6:0] c_col_last   = 7'(WORDS_PER_ROW - 1);
    localparam logic [7:0] c_row_last   = 8'(ROWS - 1);

    // Board occupies pixels x in [120,520), y in [40,440); y = 2*row.
    localparam logic [9:0] c_board_x0   = 10'd120;
    localparam logic [9:0] c_board_x1   = 10'd520;
    localparam logic [7:0] c_board_row0 = 8'd20;
    localparam logic [7:0] c_board_row1 = 8'd220;

    // Square phases are (x-120) mod 100 and (y-40) mod 100, tracked at the
    // start of each word/row; the values at x=0 / y=0 are 80 and 60.
    localparam logic [6:0] c_xph_start  = 7'd80;
    localparam logic [6:0] c_yph_start  = 7'd60;
    localparam logic [6:0] c_half_sq    = 7'd50;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_WAIT_VS = 2'd2,
        S_SWAP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic        w_wr_en;
    logic        w_busy;
    logic        w_done;
    logic        w_enter_swap;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    logic        w_vs_fall;

    logic [6:0]  r_col;
    logic [7:0]  r_row;
    logic [14:0] r_addr;
    logic [6:0]  r_xph;
    logic [6:0]  r_yph;
    logic [31:0] r_wr_data;
    logic [7:0]  r_bkg;
    logic [7:0]  r_wht;
    logic [7:0]  r_blk;
    logic        r_frame;

    logic [6:0]  w_col_nx;
    logic [7:0]  w_row_nx;
    logic [6:0]  w_xph_nx;
    logic [6:0]  w_yph_nx;

    // Palette word for the word at (col,row) given its starting x phase and
    // the row's y phase. Stepping 2 pixels per byte keeps the phase within
    // one subtraction of the 100-pixel period.
    function automatic logic [31:0] f_word(
        input logic [6:0] col,
        input logic [6:0] xph,
        input logic [7:0] row,
        input logic [6:0] yph,
        input logic [7:0] bkg,
        input logic [7:0] wht,
        input logic [7:0] blk
    );
        logic [31:0] d;
        logic [9:0]  x;
        logic [7:0]  p;
        logic        in_y;
        logic        ly;
        logic        lx;
        d    = '0;
        in_y = (row >= c_board_row0) && (row < c_board_row1);
        ly   = (yph < c_half_sq);
        for (int b = 0; b < 4; b++) begin
            x = {col, 3'b000} + 10'(2 * b);
            p = {1'b0, xph} + 8'(2 * b);
            if (p >= 8'd100) begin
                p = p - 8'd100;
            end
            lx = (p < {1'b0, c_half_sq});
            if (!in_y || (x < c_board_x0) || (x >= c_board_x1)) begin
                d[8*b +: 8] = bkg;
            end else if (lx == ly) begin
                d[8*b +: 8] = wht;
            end else begin
                d[8*b +: 8] = blk;
            end
        end
        return d;
    endfunction

    assign w_accept = (r_state == S_IDLE) && START;
    assign w_xfer   = (r_state == S_FILL) && wr.WR_READY;
    assign w_last   = (r_col == c_col_last) && (r_row == c_row_last);

`ifdef PAINTER_VSYNC_SWAP_EN
    // One sampling stage plus a history bit for edge detection.
    logic r_vs_s;
    logic r_vs_p;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vs_s <= 1'b1;
            r_vs_p <= 1'b1;
        end else begin
            r_vs_s <= VS;
            r_vs_p <= r_vs_s;
        end
    end

    assign w_vs_fall = r_vs_p && !r_vs_s;
`else
    logic w_vs_unused;
    assign w_vs_unused = VS;
    assign w_vs_fall   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_enter_swap = 1'b0;
        w_wr_en      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (START) begin
                    w_state_nx = S_FILL;
                end
            end
            S_FILL: begin
                w_wr_en = 1'b1;
                if (w_xfer && w_last) begin
`ifdef PAINTER_VSYNC_SWAP_EN
                    w_state_nx   = S_WAIT_VS;
`else
                    w_state_nx   = S_SWAP;
                    w_enter_swap = 1'b1;
`endif
                end
            end
            S_WAIT_VS: begin
                if (w_vs_fall) begin
                    w_state_nx   = S_SWAP;
                    w_enter_swap = 1'b1;
                end
            end
            S_SWAP: begin
                w_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Frame flips on entry to SWAP so FRAME and DONE change together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frame <= 1'b0;
        end else if (w_enter_swap) begin
            r_frame <= ~r_frame;
        end
    end

    // ------------------------------------------------------------------
    // Position / phase counters for the word following the current one
    // ------------------------------------------------------------------
    always_comb begin
        w_col_nx = r_col + 7'd1;
        w_row_nx = r_row;
        w_yph_nx = r_yph;
        w_xph_nx = (r_xph >= 7'd92) ? (r_xph - 7'd92) : (r_xph + 7'd8);
        if (r_col == c_col_last) begin
            w_col_nx = '0;
            w_xph_nx = c_xph_start;
            w_row_nx = r_row + 8'd1;
            w_yph_nx = (r_yph >= 7'd98) ? 7'd0 : (r_yph + 7'd2);
        end
    end

    // Address and data are registered together; the data register is loaded
    // with the next word's colours at the same edge the address advances,
    // so both hold while WR_READY is low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_xph     <= '0;
            r_yph     <= '0;
            r_wr_data <= '0;
            r_bkg     <= '0;
            r_wht     <= '0;
            r_blk     <= '0;
        end else if (w_accept) begin
            r_bkg     <= BKG_IDX;
            r_wht     <= WHT_IDX;
            r_blk     <= BLK_IDX;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_xph     <= c_xph_start;
            r_yph     <= c_yph_start;
            r_wr_data <= f_word(7'd0, c_xph_start, 8'd0, c_yph_start,
                                BKG_IDX, WHT_IDX, BLK_IDX);
        end else if (w_xfer && !w_last) begin
            r_col     <= w_col_nx;
            r_row     <= w_row_nx;
            r_addr    <= r_addr + 15'd1;
            r_xph     <= w_xph_nx;
            r_yph     <= w_yph_nx;
            r_wr_data <= f_word(w_col_nx, w_xph_nx, w_row_nx, w_yph_nx,
                                r_bkg, r_wht, r_blk);
        end
    end

    assign wr.WR_EN      = w_wr_en;
    assign wr.WR_ADDR    = r_addr;
    assign wr.WR_DATA    = r_wr_data;
    assign wr.WR_BYTE_EN = {4{w_wr_en}};
    assign FRAME         = r_frame;
    assign BUSY          = w_busy;
    assign DONE          = w_done;

endmodule
`default_nettype wire

// File: tb/tb_vram_board_painter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_board_painter
//  Description : Self-checking bench for vram_board_painter. A frame-level
//                reference model (pixel geometry from plain arithmetic)
//                predicts every output each cycle; literal checks pin the
//                reset state, key board words and swap timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_board_painter;

    localparam int c_words = 19200;
    localparam int c_last  = c_words - 1;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] BKG_IDX;
    logic [7:0] WHT_IDX;
    logic [7:0] BLK_IDX;
    logic       VS;
    logic       FRAME;
    logic       BUSY;
    logic       DONE;

    vram_board_painter_if wr_if ();

    vram_board_painter dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .BKG_IDX (BKG_IDX),
        .WHT_IDX (WHT_IDX),
        .BLK_IDX (BLK_IDX),
        .VS      (VS),
        .wr      (wr_if.master),
        .FRAME   (FRAME),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_wr  = 0;
    bit chk_en = 1'b0;
    logic [31:0] cap [0:c_last];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected word from pixel geometry: word a covers row a/80, x from
    // (a%80)*8, y = 2*row; board squares are 50 pixels.
    function automatic logic [31:0] ref_word(input int a, input logic [7:0] bk,
                                             input logic [7:0] wh, input logic [7:0] bl);
        logic [31:0] d;
        int row, col, x, y;
        bit light;
        row = a / 80;
        col = a % 80;
        y   = row * 2;
        d   = '0;
        for (int b = 0; b < 4; b++) begin
            x = col * 8 + 2 * b;
            if (x < 120 || x >= 520 || y < 40 || y >= 440) begin
                d[8*b +: 8] = bk;
            end else begin
                light = ((((x - 120) % 100) < 50) == (((y - 40) % 100) < 50));
                d[8*b +: 8] = light ? wh : bl;
            end
        end
        return d;
    endfunction

    // Reference model: what the sequencer must be doing after each edge.
    bit         m_fill, m_busy, m_wait, m_done, m_frame;
    int         m_cnt;
    logic [7:0] m_bkg, m_wht, m_blk;
    logic       vs_q = 1'b1, vs_qq = 1'b1;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        vs_q  <= VS;
        vs_qq <= vs_q;
        if (RESET) begin
            m_fill  <= 1'b0;
            m_busy  <= 1'b0;
            m_wait  <= 1'b0;
            m_done  <= 1'b0;
            m_frame <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_done) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (START) begin
                    m_bkg  <= BKG_IDX;
                    m_wht  <= WHT_IDX;
                    m_blk  <= BLK_IDX;
                    m_fill <= 1'b1;
                    m_busy <= 1'b1;
                    m_cnt  <= 0;
                end
            end else if (m_fill) begin
                if (wr_if.WR_READY) begin
                    if (m_cnt == c_last) begin
                        m_fill <= 1'b0;
`ifdef PAINTER_VSYNC_SWAP_EN
                        m_wait <= 1'b1;
`else
                        m_done  <= 1'b1;
                        m_frame <= ~m_frame;
`endif
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end else if (m_wait && vs_qq && !vs_q) begin
                m_wait  <= 1'b0;
                m_done  <= 1'b1;
                m_frame <= ~m_frame;
            end
        end
    end

    // Per-cycle comparison against the model, plus capture of written words.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("wr_en", {31'd0, wr_if.WR_EN}, {31'd0, m_fill});
            check("byte_en", {28'd0, wr_if.WR_BYTE_EN}, m_fill ? 32'hF : 32'h0);
            if (m_fill) begin
                check("wr_addr", {17'd0, wr_if.WR_ADDR}, 32'(m_cnt));
                check("wr_data", wr_if.WR_DATA, ref_word(m_cnt, m_bkg, m_wht, m_blk));
            end
            check("busy", {31'd0, BUSY}, {31'd0, m_busy});
            check("done", {31'd0, DONE}, {31'd0, m_done});
            check("frame", {31'd0, FRAME}, {31'd0, m_frame});
            if (wr_if.WR_EN === 1'b1 && wr_if.WR_READY === 1'b1 && wr_if.WR_ADDR < 15'(c_words)) begin
                cap[wr_if.WR_ADDR] = wr_if.WR_DATA;
                n_wr++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits for WR_EN to drop after a fill; optionally randomises WR_READY
    // and injects a START with other indices part way through.
    task automatic run_fill(input bit rnd_ready, input bit poke_start, input int budget);
        int k = 0;
        while (wr_if.WR_EN === 1'b1 && k < budget) begin
            wr_if.WR_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start && k == 1000) begin
                START   = 1'b1;
                BKG_IDX = 8'h11;
                WHT_IDX = 8'h22;
                BLK_IDX = 8'h33;
            end else begin
                START = 1'b0;
            end
            tick();
            k++;
        end
        START = 1'b0;
        check("fill_timeout", {31'd0, wr_if.WR_EN}, 32'd0);
    endtask

    // Completes the swap after the fill and checks its timing.
    task automatic finish_swap(input logic exp_frame);
`ifdef PAINTER_VSYNC_SWAP_EN
        check("wait_vs_done", {31'd0, DONE}, 32'd0);
        check("wait_vs_busy", {31'd0, BUSY}, 32'd1);
        repeat (100) tick();
        check("vs_hold_frame", {31'd0, FRAME}, {31'd0, ~exp_frame});
        VS = 1'b0;
        tick();
        check("vs_plus1_done", {31'd0, DONE}, 32'd0);
        tick();
        check("vs_plus2_done", {31'd0, DONE}, 32'd1);
        check("vs_plus2_frame", {31'd0, FRAME}, {31'd0, exp_frame});
        tick();
        check("vs_plus3_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) tick();
        VS = 1'b1;
        repeat (3) tick();
`else
        check("swap_done", {31'd0, DONE}, 32'd1);
        check("swap_frame", {31'd0, FRAME}, {31'd0, exp_frame});
        tick();
        check("swap_idle_busy", {31'd0, BUSY}, 32'd0);
        tick();
`endif
    endtask

    initial begin
        #(3_000_000 * 20);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc_start;
        logic [7:0] w0;
        RESET = 1'b1;
        START = 1'b0;
        VS    = 1'b1;
        BKG_IDX = 8'h00;
        WHT_IDX = 8'h00;
        BLK_IDX = 8'h00;
        wr_if.WR_READY = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_wr_en", {31'd0, wr_if.WR_EN}, 32'd0);
        check("rst_addr", {17'd0, wr_if.WR_ADDR}, 32'd0);
        check("rst_data", wr_if.WR_DATA, 32'd0);
        check("rst_byte_en", {28'd0, wr_if.WR_BYTE_EN}, 32'd0);
        check("rst_frame", {31'd0, FRAME}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        RESET = 1'b0;
        tick();

        // Reset in the middle of a fill
        BKG_IDX = 8'($urandom);
        WHT_IDX = 8'($urandom);
        BLK_IDX = 8'($urandom);
        wr_if.WR_READY = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_busy", {31'd0, BUSY}, 32'd1);
        check("start_addr0", {17'd0, wr_if.WR_ADDR}, 32'd0);
        repeat (500) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("abort_wr_en", {31'd0, wr_if.WR_EN}, 32'd0);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_frame", {31'd0, FRAME}, 32'd0);
        repeat (2) tick();

        // Full fill with fixed indices, WR_READY held high
        BKG_IDX = 8'h05;
        WHT_IDX = 8'h0A;
        BLK_IDX = 8'h0F;
        wr_if.WR_READY = 1'b1;
        n_wr = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc_start = cyc;
        check("fill1_first_addr", {17'd0, wr_if.WR_ADDR}, 32'd0);
        run_fill(1'b0, 1'b0, 25000);
        check("fill1_cycles", 32'(cyc - cyc_start), 32'd19200);
        check("fill1_writes", 32'(n_wr), 32'd19200);
        check("word_0", cap[0], 32'h05050505);
        check("word_1615", cap[1615], 32'h0A0A0A0A);
        check("word_1621", cap[1621], 32'h0F0F0F0A);
        check("word_1664", cap[1664], 32'h0F0F0F0F);
        check("word_1665", cap[1665], 32'h05050505);
        check("word_17615", cap[17615], 32'h05050505);
        finish_swap(1'b1);

        // Random WR_READY, random indices, START injected during the fill
        w0 = 8'($urandom_range(1, 255));
        BKG_IDX = 8'($urandom);
        WHT_IDX = w0;
        BLK_IDX = 8'($urandom);
        n_wr = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        run_fill(1'b1, 1'b1, 60000);
        wr_if.WR_READY = 1'b1;
        check("fill2_writes", 32'(n_wr), 32'd19200);
        check("fill2_word_1615", cap[1615], {4{w0}});
        finish_swap(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
